// File: rtl/lbuf_sched_pkg.sv
// Shared types, default geometry and derived-constant helpers for the line-buffer scheduler.
package lbuf_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned HRES_DFLT   = 640;
    localparam int unsigned VRES_DFLT   = 480;
    localparam int unsigned BURST_DFLT  = 128;
    localparam int unsigned NLINES_DFLT = 8;
    localparam int unsigned WIN_DFLT    = 3;

    localparam int unsigned REQ_LEN_W = 12;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic int unsigned bursts_per_line(input int unsigned hres, input int unsigned burst);
        return hres / burst;
    endfunction

    function automatic int unsigned num_windows(input int unsigned vres, input int unsigned win);
        return vres - win + 1;
    endfunction

    localparam int unsigned BURSTS_PER_LINE = HRES_DFLT / BURST_DFLT;
    localparam int unsigned NWIN            = VRES_DFLT - WIN_DFLT + 1;
    localparam int unsigned IDX_W           = $clog2(NLINES_DFLT);

endpackage

// File: rtl/lbuf_sched_if.sv
// Burst-request, pixel-write and window handshake bundle around the scheduler.
interface lbuf_sched_if
    import lbuf_sched_pkg::*;
#(
    parameter int unsigned BASE_W = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [REQ_LEN_W-1:0] req_len;
    logic                 px_wr_en;
    logic                 win_valid;
    logic [BASE_W-1:0]    win_base;
    logic                 win_done;

    // Scheduler side.
    modport master (
        output req_valid, req_len, win_valid, win_base,
        input  req_ready, px_wr_en, win_done
    );

    // AXI master, pixel converter and window engine side.
    modport slave (
        input  req_valid, req_len, win_valid, win_base,
        output req_ready, px_wr_en, win_done
    );
endinterface

// File: rtl/lbuf_ring_cnt.sv
// Modulo-N counter with synchronous clear, increment and a wrap pulse on the N-1 -> 0 step.
module lbuf_ring_cnt #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_c_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count; clear wins over increment.
    always_comb begin
        cnt_d    = cnt_q;
        wrap_c_o = inc_i && !clr_i && (cnt_q == W'(N - 1));
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = wrap_c_o ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/lbuf_sched.sv
// Line-buffer scheduler: throttles AXI burst requests to ring space, tracks complete lines
// and hands WIN-line windows to the window engine.
module lbuf_sched
    import lbuf_sched_pkg::*;
#(
    parameter int unsigned HRES   = HRES_DFLT,
    parameter int unsigned VRES   = VRES_DFLT,
    parameter int unsigned BURST  = BURST_DFLT,
    parameter int unsigned NLINES = NLINES_DFLT,
    parameter int unsigned WIN    = WIN_DFLT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start_i,
    output logic          frame_done_o,
    output logic          busy_o,
    output logic          overflow_o,
    lbuf_sched_if.master  bus
);
    localparam int unsigned LINE_BURSTS = bursts_per_line(HRES, BURST);
    localparam int unsigned FRAME_WINS  = num_windows(VRES, WIN);
    localparam int unsigned HEAD_W      = cnt_width(NLINES);
    localparam int unsigned BIDX_W      = cnt_width(LINE_BURSTS);
    localparam int unsigned PX_W        = cnt_width(HRES);
    localparam int unsigned LREQ_W      = cnt_width(VRES + 1);
    localparam int unsigned LCNT_W      = cnt_width(NLINES + 1);
    localparam int unsigned SUM_W       = LCNT_W + 1;
    localparam int unsigned WCNT_W      = cnt_width(FRAME_WINS + 1);

    state_e              state_q, state_d;
    logic [LREQ_W-1:0]   lines_req_q, lines_req_d;
    logic [LCNT_W-1:0]   inflight_q, inflight_d;
    logic [LCNT_W-1:0]   lines_valid_q, lines_valid_d;
    logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic                req_valid_q, req_valid_d;
    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;

    logic [BIDX_W-1:0]   burst_idx_q;
    logic [PX_W-1:0]     px_cnt_q;
    logic [HEAD_W-1:0]   head_q;

    logic                start_c, hs_c, px_bad_c, px_ok_c, win_ack_c;
    logic                line_req_c, line_done_c, head_wrap_c;
    logic                burst_open_c;
    logic [SUM_W-1:0]    ring_sum_c;

    // Per-cycle events; a pixel that raises overflow is not counted.
    assign start_c   = (state_q == ST_IDLE) && frame_start_i;
    assign hs_c      = req_valid_q && bus.req_ready;
    assign px_bad_c  = bus.px_wr_en &&
                       ((state_q == ST_IDLE) || ((inflight_q == '0) && (px_cnt_q == '0)));
    assign px_ok_c   = bus.px_wr_en && !px_bad_c;
    assign win_ack_c = bus.win_done && win_valid_q;

    lbuf_ring_cnt #(.N(LINE_BURSTS), .W(BIDX_W)) u_burst_idx (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_c),
        .inc_i    (hs_c),
        .cnt_o    (burst_idx_q),
        .wrap_c_o (line_req_c)
    );

    lbuf_ring_cnt #(.N(HRES), .W(PX_W)) u_px_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_c),
        .inc_i    (px_ok_c),
        .cnt_o    (px_cnt_q),
        .wrap_c_o (line_done_c)
    );

    lbuf_ring_cnt #(.N(NLINES), .W(HEAD_W)) u_head (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_c),
        .inc_i    (win_ack_c),
        .cnt_o    (head_q),
        .wrap_c_o (head_wrap_c)
    );

    // Next state, line bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d       = state_q;
        lines_req_d   = lines_req_q;
        inflight_d    = inflight_q;
        lines_valid_d = lines_valid_q;
        win_cnt_d     = win_cnt_q;
        burst_open_c  = (burst_idx_q != '0);

        if (start_c) begin
            lines_req_d   = '0;
            inflight_d    = '0;
            lines_valid_d = '0;
            win_cnt_d     = '0;
            burst_open_c  = 1'b0;
        end else begin
            if (line_req_c) begin
                lines_req_d = lines_req_q + LREQ_W'(1);
            end
            case ({line_req_c, line_done_c})
                2'b10:   inflight_d = inflight_q + LCNT_W'(1);
                2'b01:   inflight_d = inflight_q - LCNT_W'(1);
                default: inflight_d = inflight_q;
            endcase
            case ({line_done_c, win_ack_c})
                2'b10:   lines_valid_d = lines_valid_q + LCNT_W'(1);
                2'b01:   lines_valid_d = lines_valid_q - LCNT_W'(1);
                default: lines_valid_d = lines_valid_q;
            endcase
            if (win_ack_c) begin
                win_cnt_d = win_cnt_q + WCNT_W'(1);
            end
            if (hs_c) begin
                burst_open_c = !line_req_c;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (win_cnt_d == WCNT_W'(FRAME_WINS)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d       = ST_IDLE;
                lines_valid_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Ring occupancy counts both resident and requested-but-unwritten lines.
        ring_sum_c   = SUM_W'(lines_valid_d) + SUM_W'(inflight_d);
        req_valid_d  = (state_d == ST_RUN) &&
                       ((req_valid_q && !hs_c) ||
                        ((lines_req_d < LREQ_W'(VRES)) &&
                         (burst_open_c || (ring_sum_c < SUM_W'(NLINES)))));
        win_valid_d  = (state_d == ST_RUN) && (lines_valid_d >= LCNT_W'(WIN));
        frame_done_d = (state_d == ST_DRAIN);
        busy_d       = (state_d != ST_IDLE);
        overflow_d   = overflow_q || px_bad_c;
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lines_req_q   <= '0;
            inflight_q    <= '0;
            lines_valid_q <= '0;
            win_cnt_q     <= '0;
            req_valid_q   <= 1'b0;
            win_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lines_req_q   <= lines_req_d;
            inflight_q    <= inflight_d;
            lines_valid_q <= lines_valid_d;
            win_cnt_q     <= win_cnt_d;
            req_valid_q   <= req_valid_d;
            win_valid_q   <= win_valid_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_len   = REQ_LEN_W'(BURST);
    assign bus.win_valid = win_valid_q;
    assign bus.win_base  = head_q;
    assign frame_done_o  = frame_done_q;
    assign busy_o        = busy_q;
    assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_lbuf_sched.sv
// Bench for lbuf_sched: directed frame scenarios plus randomized frames against a reference model.
module tb_lbuf_sched;
    localparam int HRES   = 16;
    localparam int BURST  = 8;
    localparam int VRES   = 6;
    localparam int NLINES = 4;
    localparam int WIN    = 3;
    localparam int BPL    = HRES / BURST;
    localparam int NWIN   = VRES - WIN + 1;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic frame_done, busy, overflow;

    lbuf_sched_if #(.BASE_W(2)) bus ();

    lbuf_sched #(
        .HRES(HRES), .VRES(VRES), .BURST(BURST), .NLINES(NLINES), .WIN(WIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start),
        .frame_done_o  (frame_done),
        .busy_o        (busy),
        .overflow_o    (overflow),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Reference model: frame progress as totals of bursts granted, pixels accepted, windows freed.
    int m_st, m_btot, m_px, m_wins, m_ovf;
    int e_req, e_win, e_base, e_fd, e_busy;

    int n_cmp, n_bad;
    int hs_cnt, fd_cnt, px_written;
    int hs0, fd0, b0;
    int bases[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int hs, ack, in_flight, px_ok, nst, hold, lreq, ldone;
        if (rst) begin
            m_st = S_IDLE; m_btot = 0; m_px = 0; m_wins = 0; m_ovf = 0;
            e_req = 0; e_win = 0; e_base = 0; e_fd = 0; e_busy = 0;
        end else begin
            hs        = (e_req != 0 && bus.req_ready) ? 1 : 0;
            ack       = (e_win != 0 && bus.win_done) ? 1 : 0;
            in_flight = m_btot / BPL - m_px / HRES;
            px_ok     = (bus.px_wr_en && m_st != S_IDLE &&
                         !(in_flight == 0 && (m_px % HRES) == 0)) ? 1 : 0;
            if (bus.px_wr_en && px_ok == 0) m_ovf = 1;
            hold = (e_req != 0 && hs == 0) ? 1 : 0;
            nst  = m_st;
            if (m_st == S_IDLE) begin
                if (frame_start) begin
                    nst = S_RUN; m_btot = 0; m_px = 0; m_wins = 0;
                end
            end else begin
                m_btot += hs;
                m_px   += px_ok;
                m_wins += ack;
                if (m_st == S_RUN && m_wins == NWIN) nst = S_DRAIN;
                else if (m_st == S_DRAIN) nst = S_IDLE;
            end
            m_st  = nst;
            lreq  = m_btot / BPL;
            ldone = m_px / HRES;
            // Lines occupying the ring = requested lines minus freed lines.
            e_req  = (m_st == S_RUN && (hold != 0 ||
                      (lreq < VRES && ((m_btot % BPL) != 0 || (lreq - m_wins) < NLINES)))) ? 1 : 0;
            e_win  = (m_st == S_RUN && (ldone - m_wins) >= WIN) ? 1 : 0;
            e_base = m_wins % NLINES;
            e_fd   = (m_st == S_DRAIN) ? 1 : 0;
            e_busy = (m_st != S_IDLE) ? 1 : 0;
        end
    endtask

    // One clock: advance the model, observe pre-edge handshakes, then compare after the edge.
    task automatic tick();
        model_step();
        if (!rst && bus.req_valid && bus.req_ready) hs_cnt++;
        if (!rst && bus.win_done && bus.win_valid) bases.push_back(int'(bus.win_base));
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        chk("req_valid",  int'(bus.req_valid), e_req);
        chk("req_len",    int'(bus.req_len), BURST);
        chk("win_valid",  int'(bus.win_valid), e_win);
        chk("win_base",   int'(bus.win_base), e_base);
        chk("frame_done", int'(frame_done), e_fd);
        chk("busy",       int'(busy), e_busy);
        chk("overflow",   int'(overflow), m_ovf);
    endtask

    task automatic start_frame();
        hs0 = hs_cnt; fd0 = fd_cnt; b0 = bases.size(); px_written = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Drive a frame to completion: writer fills only fully requested lines, consumer acks windows.
    task automatic run_frame(input int max_cyc, input bit rnd);
        int wd;
        int avail;
        bit done_ok;
        wd = -1;
        done_ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            avail = (m_btot / BPL) * HRES - px_written;
            bus.px_wr_en = (avail > 0) && (!rnd || $urandom_range(0, 3) != 0);
            if (bus.px_wr_en) px_written++;
            bus.req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.win_done = 1'b0;
            frame_start = 1'b0;
            if (wd < 0 && e_win != 0) wd = rnd ? int'($urandom_range(0, 3)) : 2;
            if (wd == 0) begin
                bus.win_done = 1'b1;
                wd = -1;
            end else if (wd > 0) begin
                wd--;
            end
            if (rnd && $urandom_range(0, 15) == 0) bus.win_done = 1'b1;
            if (rnd && m_st != S_IDLE && $urandom_range(0, 31) == 0) frame_start = 1'b1;
            tick();
            if (m_st == S_IDLE) begin
                done_ok = 1'b1;
                break;
            end
        end
        bus.px_wr_en = 1'b0;
        bus.win_done = 1'b0;
        frame_start = 1'b0;
        chk("frame_completes", int'(done_ok), 1);
    endtask

    task automatic check_frame_totals(input string tag);
        chk({tag, "_handshakes"}, hs_cnt - hs0, VRES * BPL);
        chk({tag, "_frame_done_pulses"}, fd_cnt - fd0, 1);
        chk({tag, "_windows"}, bases.size() - b0, NWIN);
        for (int i = 0; i < NWIN; i++) begin
            if (b0 + i < bases.size()) chk({tag, "_win_base_seq"}, bases[b0 + i], i % NLINES);
        end
        chk({tag, "_busy_end"}, int'(busy), 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; hs_cnt = 0; fd_cnt = 0; px_written = 0;
        hs0 = 0; fd0 = 0; b0 = 0;
        rst = 1'b1; frame_start = 1'b0;
        bus.req_ready = 1'b0; bus.px_wr_en = 1'b0; bus.win_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_req_valid", int'(bus.req_valid), 0);
        chk("reset_req_len", int'(bus.req_len), 8);
        chk("reset_busy", int'(busy), 0);

        // Ring fills with 4 lines of requests and then stops without any writes.
        bus.req_ready = 1'b1;
        start_frame();
        chk("req_first_cycle", int'(bus.req_valid), 1);
        repeat (20) tick();
        chk("bp_handshakes", hs_cnt - hs0, 8);
        chk("bp_req_low", int'(bus.req_valid), 0);
        chk("bp_overflow", int'(overflow), 0);

        // Three full lines raise the window one cycle after the 48th pixel.
        bus.px_wr_en = 1'b1;
        repeat (47) tick();
        px_written += 47;
        chk("win_before_px48", int'(bus.win_valid), 0);
        tick();
        px_written++;
        chk("win_rise", int'(bus.win_valid), 1);
        chk("win_rise_base", int'(bus.win_base), 0);

        // Fourth line completes on the same cycle the first window is released.
        repeat (15) tick();
        px_written += 15;
        bus.win_done = 1'b1;
        tick();
        px_written++;
        bus.win_done = 1'b0;
        bus.px_wr_en = 1'b0;
        chk("simul_win_valid", int'(bus.win_valid), 1);
        chk("simul_win_base", int'(bus.win_base), 1);

        run_frame(600, 1'b0);
        check_frame_totals("frame1");

        // Stray pixel in IDLE sets the sticky error flag.
        bus.px_wr_en = 1'b1;
        tick();
        bus.px_wr_en = 1'b0;
        chk("overflow_set", int'(overflow), 1);
        tick();
        start_frame();
        run_frame(3000, 1'b1);
        chk("overflow_sticky", int'(overflow), 1);
        check_frame_totals("frame2");

        // Reset in the middle of a frame after five granted bursts.
        bus.req_ready = 1'b1;
        start_frame();
        for (int c = 0; c < 50 && (hs_cnt - hs0) < 5; c++) tick();
        chk("mid_handshakes", hs_cnt - hs0, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_ready = 1'b0;
        chk("rst_mid_req_valid", int'(bus.req_valid), 0);
        chk("rst_mid_win_valid", int'(bus.win_valid), 0);
        chk("rst_mid_win_base", int'(bus.win_base), 0);
        chk("rst_mid_frame_done", int'(frame_done), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_overflow", int'(overflow), 0);
        tick();
        start_frame();
        run_frame(3000, 1'b1);
        check_frame_totals("frame3");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
